// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: raster sequencer for 3x3 window reads.
// Issues one read per position and retires results after the filter pipe.
module window_scan_ctrl #(
    parameter int COLS = 256,
    parameter int ROWS = 32,
    parameter int LAT  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            stall,
    input  logic                            abort,
    output logic                            rd,
    output logic                            wr,
    output logic [$clog2(COLS)-1:0]         col,
    output logic [$clog2(ROWS)-1:0]         row,
    output logic [$clog2(COLS*ROWS):0]      wr_cnt,
    output logic                            busy,
    output logic                            done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int NW = $clog2(COLS*ROWS) + 1;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic            last_pos;

    assign last_pos = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Read strobe: abort overrides an otherwise legal read.
    assign rd     = (state_q == READ) && !stall && !abort;
    assign wr     = vld_q[LAT-1];
    assign col    = col_q;
    assign row    = row_q;
    assign wr_cnt = cnt_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

    // Next-state, scan position, result pipe and write counter.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        vld_d   = LAT'({vld_q, rd});

        if (wr) begin
            cnt_d = cnt_q + NW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    col_d   = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (rd) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_pos) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave once the result on the write port is the last one.
                if (vld_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any results still in the pipe.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb_window_scan_ctrl: scoreboard bench for the window scan sequencer.
// Expected reads, writes and done pulses come from a position-level model.
module tb_window_scan_ctrl;

    localparam int COLS = 256;
    localparam int ROWS = 32;
    localparam int LAT  = 3;
    localparam int N    = COLS * ROWS;
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int NW   = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic          rd, wr, busy, done;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [NW-1:0] wr_cnt;

    window_scan_ctrl #(
        .COLS(COLS),
        .ROWS(ROWS),
        .LAT (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stall (stall),
        .abort (abort),
        .rd    (rd),
        .wr    (wr),
        .col   (col),
        .row   (row),
        .wr_cnt(wr_cnt),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int col;
        int row;
    } rd_exp_t;

    typedef struct {
        int c;
        int cnt;
    } done_exp_t;

    rd_exp_t   rdq[$];
    int        wrq[$];
    done_exp_t dq[$];

    bit exp_busy = 1'b0;
    bit mon_en = 1'b0;
    int chk_rst_cyc = -1;
    int chk_clr_cyc = -1;
    int n_chk = 0;
    int n_fail = 0;

    // model: 0 idle, 1 reading, 2 waiting for done
    int ph = 0;
    int pos, nrd, last_rd, end_c, done_c;
    int stall_pos, stall_len, abort_pos, p_stall, noise, rst_drain;
    int stall_rem;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endfunction

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        end_c  = cyc;
        done_c = cyc + 2;
        if (nrd > 0 && last_rd + LAT + 1 > done_c) done_c = last_rd + LAT + 1;
        ph = 2;
        dq.push_back('{done_c, nrd});
    endtask

    task automatic do_reset();
        int keep[$];
        foreach (wrq[i]) if (wrq[i] <= cyc) keep.push_back(wrq[i]);
        wrq = keep;
        dq.delete();
        ph = 0;
        stall_rem = 0;
        chk_rst_cyc = cyc + 1;
    endtask

    task automatic one_cycle();
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        exp_busy = (ph != 0);
        case (ph)
            1: begin
                if (stall_rem > 0) begin
                    stall = 1'b1;
                    stall_rem--;
                end else if (pos == stall_pos) begin
                    stall = 1'b1;
                    stall_rem = stall_len - 1;
                    stall_pos = -1;
                end else begin
                    stall = ($urandom_range(99) < p_stall);
                end
                if (pos == abort_pos) begin
                    abort = 1'b1;
                    stall = 1'b0;
                end
                if (noise != 0) start = ($urandom_range(9) == 0);
                if (abort) begin
                    end_frame();
                end else if (!stall) begin
                    rdq.push_back('{cyc, pos % COLS, pos / COLS});
                    wrq.push_back(cyc + LAT);
                    last_rd = cyc;
                    pos++;
                    nrd++;
                    if (pos == N) end_frame();
                end
            end
            2: begin
                stall = 1'($urandom_range(1));
                abort = 1'($urandom_range(1));
                if (noise != 0) start = (cyc == done_c) || ($urandom_range(3) == 0);
                if (rst_drain != 0 && cyc == end_c + 1) begin
                    rst_n = 1'b1;
                    do_reset();
                end else if (cyc == done_c) begin
                    ph = 0;
                end
            end
            default: begin
                stall = 1'($urandom_range(1));
                abort = 1'($urandom_range(1));
            end
        endcase
    endtask

    task automatic run_frame(input int sp, input int sl, input int ap,
                             input int ps, input int nz, input int rdn);
        int budget;
        stall_pos = sp;
        stall_len = sl;
        abort_pos = ap;
        p_stall   = ps;
        noise     = nz;
        rst_drain = rdn;
        stall_rem = 0;
        wait_edge();
        exp_busy = 1'b0;
        start = 1'b1;
        stall = 1'($urandom_range(1));
        abort = 1'($urandom_range(1));
        rst_n = 1'b0;
        ph = 1;
        pos = 0;
        nrd = 0;
        last_rd = -100;
        chk_clr_cyc = cyc + 1;
        budget = 0;
        do begin
            wait_edge();
            one_cycle();
            budget++;
        end while (ph != 0 && budget < 20000);
        chk("frame_timeout", 32'(ph), 32'd0);
        ph = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT is due to respond.
    always @(negedge clk) begin : mon
        rd_exp_t   r;
        done_exp_t d;
        bit        e;
        if (mon_en) begin
            e = (rdq.size() > 0) && (rdq[0].c == cyc);
            chk("rd", 32'(rd), 32'(e));
            if (e) begin
                r = rdq.pop_front();
                if (rd) begin
                    chk("col", 32'(col), 32'(r.col));
                    chk("row", 32'(row), 32'(r.row));
                end
            end
            e = (wrq.size() > 0) && (wrq[0] == cyc);
            chk("wr", 32'(wr), 32'(e));
            if (e) void'(wrq.pop_front());
            e = (dq.size() > 0) && (dq[0].c == cyc);
            chk("done", 32'(done), 32'(e));
            if (e) begin
                d = dq.pop_front();
                chk("wr_cnt_done", 32'(wr_cnt), 32'(d.cnt));
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            if (cyc == chk_rst_cyc) begin
                chk("rst_rd", 32'(rd), 32'd0);
                chk("rst_wr", 32'(wr), 32'd0);
                chk("rst_col", 32'(col), 32'd0);
                chk("rst_row", 32'(row), 32'd0);
                chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end
            if (cyc == chk_clr_cyc) begin
                chk("clr_wr_cnt", 32'(wr_cnt), 32'd0);
                chk("clr_col", 32'(col), 32'd0);
                chk("clr_row", 32'(row), 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_busy = 1'b0;
        chk_rst_cyc = cyc;
        mon_en = 1'b1;
        wait_edge();
        one_cycle();

        run_frame(-1, 0, -1, 0, 0, 0);
        run_frame(100, 5, -1, 0, 0, 0);
        run_frame(-1, 0, 2 * COLS + 10, 0, 0, 0);
        run_frame(-1, 0, -1, 20, 1, 0);
        run_frame(-1, 0, int'($urandom_range(600, 2)), 10, 1, 0);
        run_frame(-1, 0, 300, 0, 0, 1);
        run_frame(-1, 0, 50, 0, 0, 0);

        repeat (6) begin
            wait_edge();
            one_cycle();
        end
        chk("rdq_left", 32'(rdq.size()), 32'd0);
        chk("wrq_left", 32'(wrq.size()), 32'd0);
        chk("dq_left", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
